// File: rtl/drum_step_sequencer_if.sv
// Bus bundle for drum_step_sequencer.
//   pblrc            : sample-rate LR clock, treated as data in the mclk domain
//   run              : 1 = play, 0 = stop
//   samples_per_step : step period in sample ticks
//   pat_we/pat_addr/pat_wdata : pattern write port (one step, all voices)
//   trig             : per-voice trigger levels
//   step_idx         : index of the most recently fired step
//   step_strobe      : one-mclk pulse per fired step
// master = controller driving the sequencer, slave = the sequencer itself.
interface drum_step_sequencer_if #(
  parameter int NUM_VOICES = 4,
  parameter int STEP_BITS  = 4,
  parameter int TEMPO_BITS = 16
);
  logic                  pblrc;
  logic                  run;
  logic [TEMPO_BITS-1:0] samples_per_step;
  logic                  pat_we;
  logic [STEP_BITS-1:0]  pat_addr;
  logic [NUM_VOICES-1:0] pat_wdata;
  logic [NUM_VOICES-1:0] trig;
  logic [STEP_BITS-1:0]  step_idx;
  logic                  step_strobe;

  modport master (
    output pblrc, run, samples_per_step, pat_we, pat_addr, pat_wdata,
    input  trig, step_idx, step_strobe
  );

  modport slave (
    input  pblrc, run, samples_per_step, pat_we, pat_addr, pat_wdata,
    output trig, step_idx, step_strobe
  );
endinterface

// File: rtl/drum_step_sequencer.sv
// Pattern-driven drum step sequencer.
// Counts sample ticks (rising edges of pblrc resynchronised into mclk),
// fires one pattern step every P = max(samples_per_step, 2) ticks and
// drives the fired step's voice bits onto trig for min(TRIG_LEN, P-1) ticks.
// Ports:
//   mclk : master clock (the only clock)
//   rst  : asynchronous active-high reset
//   bus  : slave side of drum_step_sequencer_if (see interface header)
module drum_step_sequencer #(
  parameter int NUM_VOICES = 4,
  parameter int NUM_STEPS  = 16,
  parameter int STEP_BITS  = 4,
  parameter int TEMPO_BITS = 16,
  parameter int TRIG_LEN   = 4
) (
  input  logic mclk,
  input  logic rst,
  drum_step_sequencer_if.slave bus
);

  localparam logic [TEMPO_BITS-1:0] MIN_PERIOD = TEMPO_BITS'(2);
  localparam logic [TEMPO_BITS-1:0] TRIG_LEN_W = TEMPO_BITS'(TRIG_LEN);
  localparam logic [STEP_BITS-1:0]  LAST_STEP  = STEP_BITS'(NUM_STEPS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state, state_nxt;
  logic                  pb_s1, pb_s2, pb_hist;
  logic                  sample_tick;
  logic                  fire, enter_idle;
  logic [TEMPO_BITS-1:0] tick_cnt;
  logic [TEMPO_BITS-1:0] p_eff, p_m1, trig_hold;
  logic [STEP_BITS-1:0]  ptr;
  logic [STEP_BITS-1:0]  step_idx_q;
  logic [NUM_VOICES-1:0] trig_q;
  logic                  strobe_q;
  logic [NUM_VOICES-1:0] pattern [NUM_STEPS];

  // pblrc synchroniser plus history flop for edge detection
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      pb_s1   <= 1'b0;
      pb_s2   <= 1'b0;
      pb_hist <= 1'b0;
    end else begin
      pb_s1   <= bus.pblrc;
      pb_s2   <= pb_s1;
      pb_hist <= pb_s2;
    end
  end

  assign sample_tick = pb_s2 & ~pb_hist;

  // FSM state register
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.run)  state_nxt = RUN;
      RUN:     if (!bus.run) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: a step fires only while RUN is still requested, so a
  // stop sampled on a tick cycle never emits a final step.
  always_comb begin
    fire       = 1'b0;
    enter_idle = 1'b0;
    case (state)
      RUN: begin
        enter_idle = !bus.run;
        fire       = bus.run && sample_tick && (tick_cnt == '0);
      end
      default: begin
        fire       = 1'b0;
        enter_idle = 1'b0;
      end
    endcase
  end

  // Effective period and trigger hold length; hold never exceeds P-1 so at
  // least one low tick separates consecutive steps.
  always_comb begin
    p_eff     = (bus.samples_per_step < MIN_PERIOD) ? MIN_PERIOD : bus.samples_per_step;
    p_m1      = p_eff - TEMPO_BITS'(1);
    trig_hold = (TRIG_LEN_W < p_m1) ? TRIG_LEN_W : p_m1;
  end

  // Tick counter, step pointer and trigger outputs
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      tick_cnt   <= '0;
      ptr        <= '0;
      step_idx_q <= '0;
      trig_q     <= '0;
      strobe_q   <= 1'b0;
    end else begin
      strobe_q <= fire;
      if (enter_idle) begin
        tick_cnt <= '0;
        ptr      <= '0;
        trig_q   <= '0;
      end else if ((state == RUN) && sample_tick) begin
        // >= rather than == so a period shortened mid-step still wraps
        tick_cnt <= (tick_cnt >= p_m1) ? '0 : tick_cnt + TEMPO_BITS'(1);
        if (fire) begin
          step_idx_q <= ptr;
          trig_q     <= pattern[ptr];
          ptr        <= (ptr == LAST_STEP) ? '0 : ptr + STEP_BITS'(1);
        end else if (tick_cnt >= trig_hold) begin
          trig_q <= '0;
        end
      end
    end
  end

  // Pattern store; a write landing on the firing step is seen next pass
  // because the fire path reads the pre-edge register value.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_STEPS; i++) pattern[i] <= '0;
    end else if (bus.pat_we) begin
      pattern[bus.pat_addr] <= bus.pat_wdata;
    end
  end

  assign bus.trig        = trig_q;
  assign bus.step_idx    = step_idx_q;
  assign bus.step_strobe = strobe_q;

endmodule

// File: tb/tb_drum_step_sequencer.sv
// Directed bench for drum_step_sequencer. pblrc has a fixed period of
// 8 mclk cycles, so one sample tick = 8 mclk and all timing expectations
// are expressed in mclk cycles.
module tb_drum_step_sequencer;
  logic mclk = 1'b0;
  logic rst  = 1'b1;
  int   checks = 0;
  int   errors = 0;

  drum_step_sequencer_if #(.NUM_VOICES(4), .STEP_BITS(4), .TEMPO_BITS(16)) bus ();

  drum_step_sequencer #(
    .NUM_VOICES(4), .NUM_STEPS(16), .STEP_BITS(4), .TEMPO_BITS(16), .TRIG_LEN(4)
  ) dut (
    .mclk(mclk),
    .rst (rst),
    .bus (bus)
  );

  always #5 mclk = ~mclk;

  initial begin
    bus.pblrc = 1'b0;
    forever begin
      #40 bus.pblrc = ~bus.pblrc;
    end
  end

  task automatic apply_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    bus.pat_we = 1'b0;
    bus.pat_addr = '0;
    bus.pat_wdata = '0;
    bus.samples_per_step = 16'd8;
    repeat (3) @(negedge mclk);
    rst = 1'b0;
    @(negedge mclk);
  endtask

  task automatic write_pat(input logic [3:0] addr, input logic [3:0] data);
    @(negedge mclk);
    bus.pat_we = 1'b1;
    bus.pat_addr = addr;
    bus.pat_wdata = data;
    @(negedge mclk);
    bus.pat_we = 1'b0;
  endtask

  // Cycles (negedges) until step_strobe is seen; -1 on timeout.
  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      @(negedge mclk);
      n++;
    end while (bus.step_strobe !== 1'b1 && n < 2000);
    if (bus.step_strobe !== 1'b1) n = -1;
  endtask

  // Cycles trig stays non-zero from the current negedge on.
  task automatic trig_high(output int hi);
    hi = 0;
    while (bus.trig !== 4'b0000 && hi < 2000) begin
      hi++;
      @(negedge mclk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.run = 1'b0;
    bus.pat_we = 1'b0;
    bus.pat_addr = '0;
    bus.pat_wdata = '0;
    bus.samples_per_step = 16'd8;
    repeat (2) @(negedge mclk);
    checks++; if (bus.trig !== 4'b0000) begin errors++; $display("FAIL reset_trig got %b exp 0000", bus.trig); end
    checks++; if (bus.step_idx !== 4'd0) begin errors++; $display("FAIL reset_step_idx got %0d exp 0", bus.step_idx); end
    checks++; if (bus.step_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", bus.step_strobe); end
    rst = 1'b0;
    repeat (40) @(negedge mclk);
    checks++; if (bus.step_strobe !== 1'b0 || bus.trig !== 4'b0000) begin
      errors++; $display("FAIL idle_quiet got strobe=%b trig=%b exp 0/0000", bus.step_strobe, bus.trig);
    end
  endtask

  task automatic test_basic_play();
    int n, hi;
    logic [3:0] exp;
    apply_reset();
    write_pat(4'd0, 4'b0001);
    write_pat(4'd4, 4'b0100);
    bus.samples_per_step = 16'd8;
    bus.run = 1'b1;
    hi = 0;
    for (int k = 0; k <= 4; k++) begin
      wait_strobe(n);
      if (k == 0) begin
        checks++; if (n < 0) begin errors++; $display("FAIL basic_first_strobe got timeout exp strobe"); end
      end else begin
        checks++; if (hi + n !== 64) begin errors++; $display("FAIL basic_interval[%0d] got %0d exp 64", k, hi + n); end
      end
      exp = (k == 0) ? 4'b0001 : (k == 4) ? 4'b0100 : 4'b0000;
      checks++; if (bus.step_idx !== 4'(k)) begin errors++; $display("FAIL basic_step_idx[%0d] got %0d exp %0d", k, bus.step_idx, k); end
      checks++; if (bus.trig !== exp) begin errors++; $display("FAIL basic_trig[%0d] got %b exp %b", k, bus.trig, exp); end
      trig_high(hi);
      checks++; if (hi !== ((exp != 4'b0000) ? 32 : 0)) begin
        errors++; $display("FAIL basic_trig_len[%0d] got %0d exp %0d", k, hi, (exp != 4'b0000) ? 32 : 0);
      end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_wrap();
    int n, hi;
    logic [3:0] exp;
    apply_reset();
    for (int s = 0; s < 16; s++) write_pat(4'(s), 4'((s % 15) + 1));
    bus.samples_per_step = 16'd2;
    bus.run = 1'b1;
    hi = 0;
    for (int k = 0; k <= 16; k++) begin
      wait_strobe(n);
      if (k > 0) begin
        checks++; if (hi + n !== 16) begin errors++; $display("FAIL wrap_interval[%0d] got %0d exp 16", k, hi + n); end
      end
      exp = 4'(((k % 16) % 15) + 1);
      checks++; if (bus.step_idx !== 4'(k % 16)) begin errors++; $display("FAIL wrap_step_idx[%0d] got %0d exp %0d", k, bus.step_idx, k % 16); end
      checks++; if (bus.trig !== exp) begin errors++; $display("FAIL wrap_trig[%0d] got %b exp %b", k, bus.trig, exp); end
      trig_high(hi);
      checks++; if (hi !== 8) begin errors++; $display("FAIL wrap_trig_len[%0d] got %0d exp 8", k, hi); end
    end
    bus.run = 1'b0;
  endtask

  task automatic test_clamp();
    int n, hi;
    for (int c = 0; c < 2; c++) begin
      apply_reset();
      for (int s = 0; s < 4; s++) write_pat(4'(s), 4'b1111);
      bus.samples_per_step = 16'(c);
      bus.run = 1'b1;
      hi = 0;
      for (int k = 0; k < 4; k++) begin
        wait_strobe(n);
        if (k > 0) begin
          checks++; if (hi + n !== 16) begin errors++; $display("FAIL clamp%0d_interval[%0d] got %0d exp 16", c, k, hi + n); end
        end
        checks++; if (bus.trig !== 4'b1111) begin errors++; $display("FAIL clamp%0d_trig[%0d] got %b exp 1111", c, k, bus.trig); end
        trig_high(hi);
        checks++; if (hi !== 8) begin errors++; $display("FAIL clamp%0d_trig_len[%0d] got %0d exp 8", c, k, hi); end
      end
      bus.run = 1'b0;
    end
  endtask

  task automatic test_stop_restart();
    int n, cnt;
    apply_reset();
    write_pat(4'd0, 4'b0011);
    write_pat(4'd5, 4'b0011);
    bus.samples_per_step = 16'd4;
    bus.run = 1'b1;
    for (int k = 0; k <= 5; k++) wait_strobe(n);
    checks++; if (bus.step_idx !== 4'd5) begin errors++; $display("FAIL stop_at_step got %0d exp 5", bus.step_idx); end
    checks++; if (bus.trig !== 4'b0011) begin errors++; $display("FAIL stop_trig_before got %b exp 0011", bus.trig); end
    bus.run = 1'b0;
    @(negedge mclk);
    checks++; if (bus.trig !== 4'b0000) begin errors++; $display("FAIL stop_trig_cleared got %b exp 0000", bus.trig); end
    checks++; if (bus.step_idx !== 4'd5) begin errors++; $display("FAIL stop_idx_held got %0d exp 5", bus.step_idx); end
    cnt = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge mclk);
      if (bus.step_strobe === 1'b1) cnt++;
    end
    checks++; if (cnt !== 0) begin errors++; $display("FAIL stop_no_strobes got %0d exp 0", cnt); end
    checks++; if (bus.step_idx !== 4'd5) begin errors++; $display("FAIL stop_idx_still_held got %0d exp 5", bus.step_idx); end
    bus.run = 1'b1;
    wait_strobe(n);
    checks++; if (n < 0 || bus.step_idx !== 4'd0) begin errors++; $display("FAIL restart_step_idx got %0d (n=%0d) exp 0", bus.step_idx, n); end
    checks++; if (bus.trig !== 4'b0011) begin errors++; $display("FAIL restart_trig got %b exp 0011", bus.trig); end
    bus.run = 1'b0;
  endtask

  task automatic test_collision();
    int n;
    apply_reset();
    bus.samples_per_step = 16'd4;
    bus.run = 1'b1;
    wait_strobe(n);
    checks++; if (n < 0 || bus.step_idx !== 4'd0) begin errors++; $display("FAIL coll_first_step got %0d (n=%0d) exp 0", bus.step_idx, n); end
    // step 1 fires on the edge 32 cycles after step 0's strobe
    repeat (31) @(negedge mclk);
    bus.pat_we = 1'b1;
    bus.pat_addr = 4'd1;
    bus.pat_wdata = 4'b1111;
    @(negedge mclk);
    bus.pat_we = 1'b0;
    checks++; if (bus.step_strobe !== 1'b1) begin errors++; $display("FAIL coll_strobe got %b exp 1", bus.step_strobe); end
    checks++; if (bus.step_idx !== 4'd1) begin errors++; $display("FAIL coll_step_idx got %0d exp 1", bus.step_idx); end
    checks++; if (bus.trig !== 4'b0000) begin errors++; $display("FAIL coll_old_value got %b exp 0000", bus.trig); end
    for (int k = 2; k <= 17; k++) wait_strobe(n);
    checks++; if (bus.step_idx !== 4'd1) begin errors++; $display("FAIL coll_next_pass_idx got %0d exp 1", bus.step_idx); end
    checks++; if (bus.trig !== 4'b1111) begin errors++; $display("FAIL coll_new_value got %b exp 1111", bus.trig); end
    bus.run = 1'b0;
  endtask

  task automatic test_async_reset();
    int n, bad, s;
    apply_reset();
    write_pat(4'd0, 4'b0011);
    bus.samples_per_step = 16'd8;
    bus.run = 1'b1;
    wait_strobe(n);
    checks++; if (n < 0 || bus.trig !== 4'b0011) begin errors++; $display("FAIL arst_pre_trig got %b (n=%0d) exp 0011", bus.trig, n); end
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.trig !== 4'b0000) begin errors++; $display("FAIL arst_trig got %b exp 0000", bus.trig); end
    checks++; if (bus.step_strobe !== 1'b0) begin errors++; $display("FAIL arst_strobe got %b exp 0", bus.step_strobe); end
    checks++; if (bus.step_idx !== 4'd0) begin errors++; $display("FAIL arst_step_idx got %0d exp 0", bus.step_idx); end
    @(negedge mclk);
    rst = 1'b0;
    bad = 0;
    s = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge mclk);
      if (bus.trig !== 4'b0000) bad++;
      if (bus.step_strobe === 1'b1) s++;
    end
    checks++; if (bad !== 0) begin errors++; $display("FAIL arst_silent got %0d trig cycles exp 0", bad); end
    checks++; if (s < 8) begin errors++; $display("FAIL arst_still_steps got %0d strobes exp >=8", s); end
    bus.run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_play();
    test_wrap();
    test_clamp();
    test_stop_restart();
    test_collision();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/drum_step_sequencer.md
DRUM_STEP_SEQUENCER -- requirements
Module: drum_step_sequencer

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of drum trigger outputs.
REQ-002 SHALL have parameter NUM_STEPS, default 16, pattern length in steps.
REQ-003 SHALL have parameter STEP_BITS, default 4, width of step index (clog2 NUM_STEPS).
REQ-004 SHALL have parameter TEMPO_BITS, default 16, width of samples_per_step.
REQ-005 SHALL have parameter TRIG_LEN, default 4, nominal trigger high time in sample ticks.
REQ-006 SHALL have port mclk  input  1  master clock (256x sample rate), the only clock.
REQ-007 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-008 SHALL have port pblrc  input  1  sample-rate LR clock, sampled as data in mclk.
REQ-009 SHALL have port run  input  1  1 = sequencer plays, 0 = stopped.
REQ-010 SHALL have port samples_per_step  input  TEMPO_BITS  step period in sample ticks.
REQ-011 SHALL have port pat_we  input  1  pattern write enable.
REQ-012 SHALL have port pat_addr  input  STEP_BITS  pattern step to write.
REQ-013 SHALL have port pat_wdata  input  NUM_VOICES  voice-enable bits for that step.
REQ-014 SHALL have port trig  output  NUM_VOICES  per-voice trigger levels, feeding oneshot voice trig inputs.
REQ-015 SHALL have port step_idx  output  STEP_BITS  index of most recently fired step.
REQ-016 SHALL have port step_strobe  output  1  one-mclk pulse per fired step.

Function
REQ-017 SHALL pass pblrc through a 2-flop synchroniser plus one history flop; sample_tick = one mclk pulse on each synchronised rising edge.
REQ-018 SHALL implement FSM states IDLE and RUN; IDLE->RUN when run=1; RUN->IDLE in the mclk cycle after run=0 is sampled.
REQ-019 SHALL, on entering IDLE, clear trig, tick counter and next-step pointer to 0 in that same cycle; step_idx holds its value.
REQ-020 SHALL use effective period P = max(samples_per_step, 2), evaluated at every sample_tick.
REQ-021 SHALL, in RUN, fire a step on a sample_tick where tick counter == 0; first step after IDLE->RUN fires on the first sample_tick.
REQ-022 SHALL increment tick counter on each sample_tick, resetting to 0 when counter >= P-1 (covers P reduced mid-step).
REQ-023 SHALL, on firing, in the next mclk cycle: pulse step_strobe for one cycle, set step_idx = next-step pointer, set trig = pattern[pointer], increment pointer with wrap NUM_STEPS-1 -> 0.
REQ-024 SHALL hold fired trig bits high for L = min(TRIG_LEN, P-1) sample ticks, then clear all trig bits, guaranteeing >=1 low sample tick before the next step.
REQ-025 SHALL store pattern as NUM_STEPS x NUM_VOICES registers, written on mclk when pat_we=1, in any state.
REQ-026 SHALL, when a write targets the step firing in the same cycle, fire the old pattern value (read-before-write).
REQ-027 SHALL leave trig=0 for steps whose pattern bits are all zero while still pulsing step_strobe.

Reset
REQ-028 SHALL, on rst=1, asynchronously force: state IDLE, trig=0, step_strobe=0, step_idx=0, pointer=0, tick counter=0, all pattern bits=0, synchroniser flops=0.
REQ-029 SHALL resume in IDLE after rst release; mid-pattern reset loses position and pattern.

Verification
REQ-030 SHALL verify basic play: pattern[0]=4'b0001, pattern[4]=4'b0100, samples_per_step=8, run=1 -> trig[0] high 4 ticks at step 0; trig[2] high 4 ticks 32 ticks later; step_strobe every 8 ticks.
REQ-031 SHALL verify wrap: NUM_STEPS=16, samples_per_step=2 -> step_idx sequence 0..15,0; trig high exactly 1 tick per step (L=1).
REQ-032 SHALL verify clamp: samples_per_step=0 and =1 -> behaves as P=2; trig never high on consecutive steps' boundary tick.
REQ-033 SHALL verify stop/restart: run=0 at step 5 -> trig=0 next cycle, step_idx=5 held; run=1 -> next fired step_idx=0.
REQ-034 SHALL verify write collision: pat_we with pat_addr=pointer on firing cycle, old=0000, new=1111 -> trig=0000 this pass, 1111 next pass.
REQ-035 SHALL verify async reset mid-trig: rst asserted while trig=4'b0011 -> trig=0 without mclk edge; after release all steps silent.
